// File: rtl/huff_pkg.sv
// Shared types and constants for the unary-run Huffman length decoder.
package huff_pkg;

  localparam int unsigned LEN_W   = 7;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned RUN_MAX = 126;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StEmit,
    StErr
  } state_e;

endpackage

// File: rtl/huff_decode_ctrl_if.sv
// Byte-in / symbol-out handshake bundle for huff_decode_ctrl.
interface huff_decode_ctrl_if;

  logic                         byte_valid;
  logic [huff_pkg::BYTE_W-1:0]  byte_data;
  logic                         byte_ready;
  logic                         flush;
  logic                         sym_valid;
  logic [huff_pkg::LEN_W-1:0]   sym_len;
  logic                         sym_ready;
  logic [15:0]                  sym_count;
  logic                         busy;
  logic                         err_ovf;

  modport slave (
    input  byte_valid, byte_data, flush, sym_ready,
    output byte_ready, sym_valid, sym_len, sym_count, busy, err_ovf
  );

  modport master (
    output byte_valid, byte_data, flush, sym_ready,
    input  byte_ready, sym_valid, sym_len, sym_count, busy, err_ovf
  );

endinterface

// File: rtl/bit_shifter.sv
// 8-bit MSB-first shift register with a count of bits still to be consumed.
module bit_shifter
  import huff_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              shift,
  output logic              msb,
  output logic [3:0]        bits_left,
  output logic              empty
);

  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [3:0]        bits_left_q, bits_left_d;

  always_comb begin
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    if (clear) begin
      shreg_d     = '0;
      bits_left_d = '0;
    end else if (load) begin
      shreg_d     = load_data;
      bits_left_d = 4'(BYTE_W);
    end else if (shift && (bits_left_q != '0)) begin
      shreg_d     = {shreg_q[BYTE_W-2:0], 1'b0};
      bits_left_d = bits_left_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      shreg_q     <= '0;
      bits_left_q <= '0;
    end else begin
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
    end
  end

  assign msb       = shreg_q[BYTE_W-1];
  assign bits_left = bits_left_q;
  assign empty     = (bits_left_q == '0);

endmodule

// File: rtl/huff_decode_ctrl.sv
// Unary-run code length decoder: counts 1s until a 0, emits run+1 as sym_len.
// Define HUFF_LEN_CHECK_EN to trap run overflow in StErr instead of saturating.
module huff_decode_ctrl
  import huff_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  huff_decode_ctrl_if.slave  bus
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   run_q, run_d;
  logic [LEN_W-1:0]   sym_len_q, sym_len_d;
  logic [15:0]        sym_count_q, sym_count_d;
  logic               byte_ready;
  logic               sh_clear, sh_load, sh_shift;
  logic               sh_msb, sh_empty;
  logic [3:0]         sh_bits_left;
  logic               last_bit;

`ifdef HUFF_LEN_CHECK_EN
  logic err_ovf_q, err_ovf_d;
`endif

  bit_shifter u_shifter (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (sh_clear),
    .load      (sh_load),
    .load_data (bus.byte_data),
    .shift     (sh_shift),
    .msb       (sh_msb),
    .bits_left (sh_bits_left),
    .empty     (sh_empty)
  );

  assign last_bit = (sh_bits_left == 4'd1);

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    sym_len_d   = sym_len_q;
    sym_count_d = sym_count_q;
    byte_ready  = 1'b0;
    sh_clear    = 1'b0;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
`ifdef HUFF_LEN_CHECK_EN
    err_ovf_d   = err_ovf_q;
`endif
    if (bus.flush) begin
      state_d  = StIdle;
      run_d    = '0;
      sh_clear = 1'b1;
`ifdef HUFF_LEN_CHECK_EN
      err_ovf_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          byte_ready = 1'b1;
          if (bus.byte_valid) begin
            sh_load = 1'b1;
            state_d = StShift;
          end
        end
        StShift: begin
          sh_shift = 1'b1;
          if (!sh_msb) begin
            sym_len_d = run_q + 7'd1;
            run_d     = '0;
            state_d   = StEmit;
          end else if (run_q == LEN_W'(RUN_MAX)) begin
`ifdef HUFF_LEN_CHECK_EN
            err_ovf_d = 1'b1;
            state_d   = StErr;
`else
            // Saturate: the run stays at its ceiling so sym_len tops out at 127.
            if (last_bit) state_d = StIdle;
`endif
          end else begin
            run_d = run_q + 7'd1;
            if (last_bit) state_d = StIdle;
          end
        end
        StEmit: begin
          if (bus.sym_ready) begin
            sym_count_d = sym_count_q + 16'd1;
            state_d     = sh_empty ? StIdle : StShift;
          end
        end
        StErr: state_d = StErr;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      run_q       <= '0;
      sym_len_q   <= '0;
      sym_count_q <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      sym_len_q   <= sym_len_d;
      sym_count_q <= sym_count_d;
    end
  end

`ifdef HUFF_LEN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!n_rst) err_ovf_q <= 1'b0;
    else        err_ovf_q <= err_ovf_d;
  end
  assign bus.err_ovf = err_ovf_q;
`else
  assign bus.err_ovf = 1'b0;
`endif

  assign bus.byte_ready = byte_ready;
  assign bus.sym_valid  = (state_q == StEmit);
  assign bus.sym_len    = sym_len_q;
  assign bus.sym_count  = sym_count_q;
  assign bus.busy       = (state_q != StIdle) || (run_q != '0);

endmodule
